// File: rtl/seg7_scan_driver_if.sv
// Score-display bus: load/clear requests with ready handshake, plus the scanned an/seg display lines.
// master drives requests and watches the display; slave is the driver block.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4,
    parameter int VALUE_W  = 8
);
    logic                load;
    logic [VALUE_W-1:0]  value;
    logic                clear;
    logic                ready;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;

    modport master (output load, value, clear, input ready, an, seg);
    modport slave  (input load, value, clear, output ready, an, seg);
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary score -> sequential double-dabble BCD -> N-digit multiplexed 7-seg; ready low VALUE_W+1 cycles per load, loads while busy dropped.
// Define SEG7_LEADING_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int VALUE_W     = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_VAL     = 100
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_M    = 7'b1101010;
    localparam logic [6:0] SEG_A    = 7'b0001000;

    function automatic int dec_digits(input int w);
        longint m;
        int     d;
        m = (64'sd1 <<< w) - 1;
        d = 1;
        while (m >= 10) begin
            m = m / 10;
            d++;
        end
        return d;
    endfunction

    function automatic longint max_dec(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_OFF;
        endcase
    endfunction

    localparam int BCD_D = dec_digits(VALUE_W);
    localparam int BW    = 4 * BCD_D;
    localparam int PD    = (N_DIGITS > BCD_D) ? N_DIGITS : BCD_D;
    localparam int BCW   = $clog2(VALUE_W);
    localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW    = $clog2(N_DIGITS);
    localparam logic [63:0] DEC_MAX = 64'(max_dec(N_DIGITS));
    localparam logic [63:0] MAX64   = 64'(MAX_VAL);

    logic [1:0]         state;
    logic [VALUE_W-1:0] val_q;
    logic [VALUE_W-1:0] bin_q;
    logic [BW-1:0]      bcd_q;
    logic [BW-1:0]      bcd_adj;
    logic [4*PD-1:0]    bcd_pad;
    logic [BCW-1:0]     bit_cnt;
    logic [6:0]         codes      [N_DIGITS];
    logic [6:0]         next_codes [N_DIGITS];
    logic [3:0]         dig;
    logic [CW-1:0]      ref_cnt;
    logic [IW-1:0]      idx;

    assign bus.ready = (state == ST_IDLE);
    assign bcd_pad   = (4*PD)'(bcd_q);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Digits are scanned from the top so leading zeros can be recognised before they are emitted.
    always_comb begin
`ifdef SEG7_LEADING_BLANK_EN
        logic nz;
        nz = 1'b0;
`endif
        dig = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) next_codes[i] = SEG_OFF;
        if (64'(val_q) == MAX64) begin
            next_codes[0] = SEG_A;
            next_codes[1] = SEG_M;
        end else if (64'(val_q) > DEC_MAX) begin
            for (int i = 0; i < N_DIGITS; i++) next_codes[i] = SEG_DASH;
        end else begin
            for (int i = N_DIGITS - 1; i >= 0; i--) begin
                dig = bcd_pad[4*i +: 4];
`ifdef SEG7_LEADING_BLANK_EN
                if (dig != 4'd0) nz = 1'b1;
                next_codes[i] = (!nz && i != 0) ? SEG_OFF : seg_of(dig);
`else
                next_codes[i] = seg_of(dig);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            val_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < N_DIGITS; i++) codes[i] <= SEG_DASH;
        end else if (bus.clear) begin
            state <= ST_IDLE;
            for (int i = 0; i < N_DIGITS; i++) codes[i] <= SEG_DASH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        val_q   <= bus.value;
                        bin_q   <= bus.value;
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    bit_cnt        <= bit_cnt + 1'b1;
                    if (bit_cnt == BCW'(VALUE_W - 1)) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < N_DIGITS; i++) codes[i] <= next_codes[i];
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Scan position is independent of the converter so display updates never jolt the refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            bus.an  <= '1;
            bus.seg <= SEG_OFF;
        end else begin
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            bus.an  <= ~(N_DIGITS'(1) << idx);
            bus.seg <= codes[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 2-digit instance share clock and reset.
module tb_seg7_scan_driver;
    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] MM   = 7'b1101010;
    localparam logic [6:0] AA   = 7'b0001000;
    localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100, C3 = 7'b0110000,
                           C4 = 7'b0011001, C5 = 7'b0010010, C6 = 7'b0000010, C7 = 7'b1111000,
                           C8 = 7'b0000000, C9 = 7'b0010000;
    localparam logic [6:0] DIGC [10] = '{C0, C1, C2, C3, C4, C5, C6, C7, C8, C9};
`ifdef SEG7_LEADING_BLANK_EN
    localparam logic [6:0] LZ = OFF;
`else
    localparam logic [6:0] LZ = C0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(4), .VALUE_W(8)) b4 ();
    seg7_scan_driver_if #(.N_DIGITS(2), .VALUE_W(8)) b2 ();

    seg7_scan_driver #(.N_DIGITS(4), .VALUE_W(8), .REFRESH_DIV(4), .MAX_VAL(100))
        dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    seg7_scan_driver #(.N_DIGITS(2), .VALUE_W(8), .REFRESH_DIV(4), .MAX_VAL(100))
        dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct {
        int          v;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl [8];

    // Expected codes straight from the decimal value: digit i is (v / 10^i) % 10.
    function automatic logic [55:0] model(input int v, input int n);
        logic [55:0] r;
        int p;
        r = {8{OFF}};
        if (v == 100) begin
            r[6:0]  = AA;
            r[13:7] = MM;
        end else begin
            p = 1;
            for (int i = 0; i < n; i++) p = p * 10;
            if (v > p - 1) begin
                for (int i = 0; i < n; i++) r[7*i +: 7] = DASH;
            end else begin
                p = 1;
                for (int i = 0; i < n; i++) begin
`ifdef SEG7_LEADING_BLANK_EN
                    r[7*i +: 7] = (i > 0 && v < p) ? OFF : DIGC[(v / p) % 10];
`else
                    r[7*i +: 7] = DIGC[(v / p) % 10];
`endif
                    p = p * 10;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load4(input int v, input bit inject, output int low);
        @(negedge clk);
        b4.load  = 1'b1;
        b4.value = 8'(v);
        @(posedge clk);
        #1;
        b4.load  = 1'b0;
        b4.value = 8'(~v);
        low = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b4.ready) break;
            low++;
            if (inject && c == 3) begin
                b4.load  = 1'b1;
                b4.value = 8'd7;
            end else begin
                b4.load = 1'b0;
            end
        end
        b4.load = 1'b0;
        @(negedge clk);
    endtask

    task automatic load2(input int v, output int low);
        @(negedge clk);
        b2.load  = 1'b1;
        b2.value = 8'(v);
        @(posedge clk);
        #1;
        b2.load  = 1'b0;
        b2.value = 8'(~v);
        low = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b2.ready) break;
            low++;
        end
        @(negedge clk);
    endtask

    // Watch one full scan round and record the code shown for each lit digit.
    task automatic capture4(input string name, input logic [27:0] exp);
        logic [27:0] got;
        logic [3:0]  seen;
        int bad, k;
        got = '0; seen = '0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            k = -1;
            for (int i = 0; i < 4; i++) if (b4.an == 4'(~(4'b1 << i))) k = i;
            if (k < 0) bad++;
            else begin
                got[7*k +: 7] = b4.seg;
                seen[k] = 1'b1;
            end
        end
        chk(name, {32'(bad), seen, got}, {32'd0, 4'hf, exp});
    endtask

    task automatic capture2(input string name, input logic [13:0] exp);
        logic [13:0] got;
        logic [1:0]  seen;
        int bad, k;
        got = '0; seen = '0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            k = -1;
            for (int i = 0; i < 2; i++) if (b2.an == 2'(~(2'b1 << i))) k = i;
            if (k < 0) bad++;
            else begin
                got[7*k +: 7] = b2.seg;
                seen[k] = 1'b1;
            end
        end
        chk(name, {32'(bad), seen, got}, {32'd0, 2'h3, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, v;
        tbl[0] = '{42,  {LZ, LZ, C4, C2}};
        tbl[1] = '{100, {OFF, OFF, MM, AA}};
        tbl[2] = '{0,   {LZ, LZ, LZ, C0}};
        tbl[3] = '{7,   {LZ, LZ, LZ, C7}};
        tbl[4] = '{255, {LZ, C2, C5, C5}};
        tbl[5] = '{99,  {LZ, LZ, C9, C9}};
        tbl[6] = '{101, {LZ, C1, C0, C1}};
        tbl[7] = '{10,  {LZ, LZ, C1, C0}};

        b4.load = 1'b0; b4.value = '0; b4.clear = 1'b0;
        b2.load = 1'b0; b2.value = '0; b2.clear = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", b4.an, 4'hf);
        chk("rst_seg", b4.seg, OFF);
        chk("rst_ready", b4.ready, 1);
        rst = 1'b0;

        // Digit k lit after the k-th edge following reset release: index (k-1)/4 mod 4.
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", k), b4.an, 4'(~(4'b1 << (((k - 1) / 4) % 4))));
            if (k == 1) begin
                chk("first_seg", b4.seg, DASH);
                chk("first_ready", b4.ready, 1);
            end
        end

        for (int i = 0; i < 8; i++) begin
            load4(tbl[i].v, 1'b0, low);
            chk($sformatf("tbl_lat_%0d", tbl[i].v), low, 9);
            capture4($sformatf("tbl_disp_%0d", tbl[i].v), tbl[i].exp);
        end

        load4(42, 1'b1, low);
        chk("busy_load_lat", low, 9);
        capture4("busy_load_ignored", {LZ, LZ, C4, C2});

        @(negedge clk);
        b4.clear = 1'b1; b4.load = 1'b1; b4.value = 8'd55;
        @(posedge clk);
        #1;
        b4.clear = 1'b0; b4.load = 1'b0;
        @(negedge clk);
        chk("clear_load_ready", b4.ready, 1);
        capture4("clear_load_disp", {DASH, DASH, DASH, DASH});

        load4(77, 1'b0, low);
        @(negedge clk);
        b4.load = 1'b1; b4.value = 8'd99;
        @(posedge clk);
        #1;
        b4.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", b4.ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", b4.ready, 1);
        chk("mid_rst_an", b4.an, 4'hf);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_first_an", b4.an, 4'b1110);
        chk("mid_rst_first_seg", b4.seg, DASH);
        capture4("mid_rst_disp", {DASH, DASH, DASH, DASH});

        load2(255, low);
        chk("n2_lat", low, 9);
        capture2("n2_255", {DASH, DASH});
        load2(99, low);
        capture2("n2_99", {C9, C9});
        load2(100, low);
        capture2("n2_100", {MM, AA});
        load2(5, low);
        capture2("n2_5", {LZ, C5});

        for (int r = 0; r < 24; r++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 105)) : int'($urandom_range(0, 255));
            load4(v, 1'b0, low);
            chk($sformatf("rnd4_lat_%0d", v), low, 9);
            capture4($sformatf("rnd4_%0d", v), model(v, 4)[27:0]);
        end
        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, 255));
            load2(v, low);
            capture2($sformatf("rnd2_%0d", v), model(v, 2)[13:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
